// File: rtl/alu_pkg.sv
// Shared constants for the execute stage: ALU codes, FSM states, widths.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_SLL = 4'h4;
  localparam logic [3:0] ALU_SRL = 4'h5;
  localparam logic [3:0] ALU_SRA = 4'h6;
  localparam logic [3:0] ALU_NOR = 4'h7;
  localparam logic [3:0] ALU_SLT = 4'h8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(
    input logic [3:0] code
  );
    return (code == ALU_SLL) ||
           (code == ALU_SRL) ||
           (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU with a single-cycle barrel shifter.
// Undefined control codes produce a zero result.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic lt;

  always_comb begin
    lt = $signed(a) < $signed(b);
    result = '0;
    case (alu_ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_SRA: result = DATA_W'($signed(b) >>> shamt);
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// EX stage: ALU, branch/jr redirect and EX/MEM register with handshake.
// SERIAL_SHIFT_EN selects a 1-bit-per-cycle shifter FSM for shift ops.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_ctrl,
  input  logic              jr_ctrl,
  input  logic              is_beq,
  input  logic              is_bne,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] br_offset,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic              zero,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);

  state_t state, state_nxt;

  logic [DATA_W-1:0] core_res;
  logic              core_zero;
  logic [DATA_W-1:0] res_in;
  logic [DATA_W-1:0] br_tgt;
  logic [DATA_W-1:0] rpc_in;
  logic              taken;
  logic              accept;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .alu_ctrl (alu_ctrl),
    .a        (op_a),
    .b        (op_b),
    .shamt    (shamt),
    .result   (core_res),
    .zero     (core_zero)
  );

  always_comb begin
    br_tgt = pc_plus4 + (br_offset << 2);
    taken  = jr_ctrl ||
             (is_beq && (op_a == op_b)) ||
             (is_bne && (op_a != op_b));
    rpc_in = '0;
    if (jr_ctrl)
      rpc_in = op_a;
    else if (taken)
      rpc_in = br_tgt;
    res_in = jr_ctrl ? '0 : core_res;
  end

  assign accept = in_valid && in_ready;

`ifdef SERIAL_SHIFT_EN
  logic [4:0]        cnt;
  logic [3:0]        sh_op;
  logic              rv_pend;
  logic              serial_go;
  logic [DATA_W-1:0] sh_step;

  assign serial_go = accept && !jr_ctrl &&
                     is_shift(alu_ctrl) &&
                     (shamt != 5'd0);

  always_comb begin
    unique case (1'b1)
      (sh_op == ALU_SLL):
        sh_step = alu_result << 1;
      (sh_op == ALU_SRL):
        sh_step = alu_result >> 1;
      default:
        sh_step = {alu_result[DATA_W-1],
                   alu_result[DATA_W-1:1]};
    endcase
  end
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (flush)
      state_nxt = ST_IDLE;
`ifdef SERIAL_SHIFT_EN
    else if (state == ST_IDLE && serial_go)
      state_nxt = ST_SHIFT;
    else if (state == ST_SHIFT && cnt == 5'd1)
      state_nxt = ST_IDLE;
`endif
  end

  // FSM: outputs
  always_comb begin
    in_ready = rst_n &&
               (state == ST_IDLE) &&
               (!out_valid || out_ready) &&
               !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      out_store_data <= '0;
      zero           <= 1'b0;
      out_rd_addr    <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
`ifdef SERIAL_SHIFT_EN
      cnt            <= '0;
      sh_op          <= '0;
      rv_pend        <= 1'b0;
`endif
    end else if (flush) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      out_rd_addr    <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      if (accept) begin
        out_valid      <= 1'b1;
        alu_result     <= res_in;
        zero           <= (res_in == '0);
        out_store_data <= store_data;
        out_rd_addr    <= rd_addr;
        out_reg_write  <= reg_write && !jr_ctrl;
        out_mem_read   <= mem_read;
        out_mem_write  <= mem_write;
        out_mem_to_reg <= mem_to_reg;
        redirect_pc    <= rpc_in;
        redirect_valid <= taken;
`ifdef SERIAL_SHIFT_EN
        // Result register doubles as the shift accumulator
        if (serial_go) begin
          out_valid      <= 1'b0;
          redirect_valid <= 1'b0;
          alu_result     <= op_b;
          rv_pend        <= taken;
          cnt            <= shamt;
          sh_op          <= alu_ctrl;
        end
`endif
      end
`ifdef SERIAL_SHIFT_EN
      else if (state == ST_SHIFT) begin
        alu_result <= sh_step;
        cnt        <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          out_valid      <= 1'b1;
          zero           <= (sh_step == '0);
          redirect_valid <= rv_pend;
        end
      end
`endif
      else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
